// File: rtl/i2c_master_tx_if.sv
// Bundles the transaction handshake and open-drain bus lines of the write-only
// I2C master. The master modport is the controller's view; the slave modport
// is the view of whatever drives requests and models the bus (SoC or bench).
interface i2c_master_tx_if;
  logic       start_req;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sda_in;
  logic       scl;
  logic       sda_out;
  logic       busy;
  logic       ack_error;
  logic       done;

  modport master (
    input  start_req, slave_addr, tx_data, tx_valid, sda_in,
    output tx_ready, scl, sda_out, busy, ack_error, done
  );

  modport slave (
    output start_req, slave_addr, tx_data, tx_valid, sda_in,
    input  tx_ready, scl, sda_out, busy, ack_error, done
  );
endinterface

// File: rtl/i2c_master_tx.sv
// Write-only I2C bus master: START, {slave_addr, W=0}, N data bytes, STOP.
// Every bus period is split into four quarters of QTR system clocks; SCL and
// SDA are decoded from the state and the current quarter. Line outputs are
// open-drain style: 1 releases the line, 0 pulls it low.
module i2c_master_tx #(
  parameter int QTR = 5
) (
  input logic             clk,
  input logic             n_rst,
  i2c_master_tx_if.master bus
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [QW-1:0] qtr_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          nack_seen;
  logic          ack_error_q;
  logic          done_q;

  logic          qtr_end;
  logic          phase_end;
  logic          accept;
  logic          bit_slot;
  logic          ack_slot;
  logic          ack_sample;
  logic          load_data;

  // A transaction is only accepted from IDLE, so requests while busy (and in
  // the final STOP cycle) are simply never seen.
  assign qtr_end    = (qtr_cnt == QTR_LAST);
  assign phase_end  = qtr_end && (phase == 2'd3);
  assign accept     = (state == IDLE) && bus.start_req;
  assign bit_slot   = (state == ADDR) || (state == DATA);
  assign ack_slot   = (state == ADDR_ACK) || (state == DATA_ACK);
  assign ack_sample = ack_slot && (phase == 2'd2) && qtr_end;
  assign load_data  = ack_slot && phase_end && !nack_seen && bus.tx_valid;

  // State register; reset abandons any transaction without a STOP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Quarter and phase counters run only while a transaction is in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      qtr_cnt <= '0;
      phase   <= 2'd0;
    end else if (state == IDLE) begin
      qtr_cnt <= '0;
      phase   <= 2'd0;
    end else if (qtr_end) begin
      qtr_cnt <= '0;
      phase   <= phase + 2'd1;
    end else begin
      qtr_cnt <= qtr_cnt + 1'b1;
    end
  end

  // Shift register and bit counter: MSB goes out first, shifted after each
  // full bit period; the counter wraps from 0 back to 7 on entering the ACK.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift   <= 8'h00;
      bit_cnt <= 3'd7;
    end else if (accept) begin
      shift   <= {bus.slave_addr, 1'b0};
      bit_cnt <= 3'd7;
    end else if (bit_slot && phase_end) begin
      shift   <= {shift[6:0], 1'b0};
      bit_cnt <= bit_cnt - 3'd1;
    end else if (load_data) begin
      shift   <= bus.tx_data;
      bit_cnt <= 3'd7;
    end
  end

  // Acknowledge capture in the middle of the high SCL phase; the NACK flag is
  // sticky until the next accepted request.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nack_seen   <= 1'b0;
      ack_error_q <= 1'b0;
    end else if (accept) begin
      nack_seen   <= 1'b0;
      ack_error_q <= 1'b0;
    end else if (ack_sample) begin
      nack_seen <= bus.sda_in;
      if (bus.sda_in) begin
        ack_error_q <= 1'b1;
      end
    end
  end

  // Completion pulse lands in the first IDLE cycle after STOP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == STOP) && phase_end;
    end
  end

  // Next-state and bus waveform decode.
  always_comb begin
    state_nx     = state;
    bus.scl      = 1'b1;
    bus.sda_out  = 1'b1;
    bus.tx_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_req) begin
          state_nx = START;
        end
      end
      START: begin
        bus.sda_out = (phase < 2'd2);
        if (phase_end) begin
          state_nx = ADDR;
        end
      end
      ADDR, DATA: begin
        bus.scl     = phase[1];
        bus.sda_out = shift[7];
        if (phase_end && (bit_cnt == 3'd0)) begin
          state_nx = (state == ADDR) ? ADDR_ACK : DATA_ACK;
        end
      end
      ADDR_ACK, DATA_ACK: begin
        bus.scl = phase[1];
        if (phase_end) begin
          if (load_data) begin
            bus.tx_ready = 1'b1;
            state_nx     = DATA;
          end else begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        bus.scl     = (phase != 2'd0);
        bus.sda_out = (phase == 2'd3);
        if (phase_end) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.ack_error = ack_error_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Randomised bench for the write-only I2C master. A bus-level slave model
// decodes START/STOP and clocked bits from SCL/SDA and answers ACK/NACK; the
// expected bytes, pulse counts and latency come from the transaction rules.
module tb_i2c_master_tx;

  localparam int QTR = 5;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;

  i2c_master_tx_if bus ();

  i2c_master_tx #(.QTR(QTR)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int n_vectors = 0;
  int n_miscompares = 0;

  // bus-level slave model state
  logic       slave_pull = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_frame = 1'b0;
  logic       rise_seen = 1'b0;
  logic [7:0] rx_shift = 8'h00;
  int         bit_pos = 0;
  int         nack_at = -1;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         scl_pulses = 0;
  logic [7:0] cap_q[$];

  // driver results
  logic [7:0] stim_q[$];
  int         ready_cnt = 0;
  int         done_cnt = 0;
  int         done_lat = -1;

  assign bus.sda_in = bus.sda_out & ~slave_pull;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Slave model: sampled just after each rising clk edge, away from the DUT's
  // input sampling. Any SDA change with SCL high is a START or STOP.
  always @(posedge clk) begin
    #1;
    if (!n_rst) begin
      in_frame   = 1'b0;
      slave_pull = 1'b0;
      rise_seen  = 1'b0;
      bit_pos    = 0;
    end else if (prev_scl && bus.scl && prev_sda && !bus.sda_out) begin
      start_cnt++;
      in_frame   = 1'b1;
      bit_pos    = 0;
      rise_seen  = 1'b0;
      slave_pull = 1'b0;
    end else if (prev_scl && bus.scl && !prev_sda && bus.sda_out) begin
      stop_cnt++;
      in_frame   = 1'b0;
      slave_pull = 1'b0;
    end else if (in_frame && !prev_scl && bus.scl) begin
      rise_seen = 1'b1;
      if (bit_pos < 8) begin
        rx_shift = {rx_shift[6:0], bus.sda_out};
        bit_pos++;
        if (bit_pos == 8) cap_q.push_back(rx_shift);
      end else begin
        bit_pos = 0;
      end
    end else if (in_frame && prev_scl && !bus.scl) begin
      if (rise_seen) scl_pulses++;
      rise_seen  = 1'b0;
      slave_pull = (bit_pos == 8) && ((cap_q.size() - 1) != nack_at);
    end
    prev_scl = bus.scl;
    prev_sda = bus.sda_out;
  end

  // One transaction: request, feed bytes on tx_ready, optionally keep
  // start_req asserted while busy, optionally abort with reset at abort_at.
  task automatic applyStimulus(input logic [6:0] addr, input int nack_pos,
                               input bit poke, input int abort_at);
    logic [7:0] q[$];
    int  cyc0;
    int  hold;
    int  post;
    bit  pop_pending;
    bit  seen_done;
    q = stim_q;
    @(negedge clk);
    nack_at    = nack_pos;
    start_cnt  = 0;
    stop_cnt   = 0;
    scl_pulses = 0;
    cap_q      = {};
    ready_cnt  = 0;
    done_cnt   = 0;
    done_lat   = -1;
    bus.slave_addr = addr;
    bus.start_req  = 1'b1;
    bus.tx_valid   = (q.size() > 0);
    if (q.size() > 0) bus.tx_data = q[0];
    else bus.tx_data = 8'($urandom);
    @(negedge clk);
    cyc0 = cyc;
    bus.start_req = poke;
    checkOutput("busy_on_accept", 32'(bus.busy), 32'd1);
    pop_pending = 1'b0;
    seen_done   = 1'b0;
    hold        = 0;
    post        = 0;
    for (int k = 0; k < 4000 && post < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (abort_at > 0 && (cyc - cyc0) == abort_at) begin
        n_rst = 1'b0;
        #1;
        checkOutput("abort_scl", 32'(bus.scl), 32'd1);
        checkOutput("abort_sda", 32'(bus.sda_out), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_tx_ready", 32'(bus.tx_ready), 32'd0);
        checkOutput("abort_ack_error", 32'(bus.ack_error), 32'd0);
        @(negedge clk);
        bus.tx_valid  = 1'b0;
        bus.start_req = 1'b0;
        n_rst = 1'b1;
        return;
      end
      if (pop_pending) begin
        void'(q.pop_front());
        pop_pending = 1'b0;
        hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
      end
      if (hold > 0) begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        hold--;
      end else if (q.size() > 0) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = q[0];
      end else begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
      end
      #1;
      if (bus.tx_ready) begin
        ready_cnt++;
        pop_pending = 1'b1;
      end
      if (bus.done) begin
        done_cnt++;
        if (!seen_done) done_lat = cyc - cyc0;
        seen_done = 1'b1;
        bus.start_req = 1'b0;
      end
      if (seen_done) post++;
    end
    bus.start_req = 1'b0;
    if (!seen_done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Reference expectations: the number of bytes sent is the NACKed byte's
  // index when the slave refuses one (address = 0), otherwise all offered.
  task automatic checkTransaction(input logic [6:0] addr, input int nbytes, input int nack_pos);
    int sent;
    sent = (nack_pos >= 0) ? nack_pos : nbytes;
    checkOutput("latency", 32'(done_lat), 32'(4 * QTR * (2 + 9 * (1 + sent))));
    checkOutput("tx_ready_pulses", 32'(ready_cnt), 32'(sent));
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("ack_error", 32'(bus.ack_error), (nack_pos >= 0) ? 32'd1 : 32'd0);
    checkOutput("start_conditions", 32'(start_cnt), 32'd1);
    checkOutput("stop_conditions", 32'(stop_cnt), 32'd1);
    checkOutput("scl_pulses", 32'(scl_pulses), 32'(9 * (1 + sent)));
    checkOutput("bytes_on_bus", 32'(cap_q.size()), 32'(1 + sent));
    for (int i = 0; i < cap_q.size() && i <= sent; i++) begin
      if (i == 0) checkOutput("addr_byte", 32'(cap_q[0]), 32'({addr, 1'b0}));
      else checkOutput($sformatf("data_byte%0d", i), 32'(cap_q[i]), 32'(stim_q[i-1]));
    end
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_scl", 32'(bus.scl), 32'd1);
    checkOutput("idle_sda", 32'(bus.sda_out), 32'd1);
  endtask

  initial begin
    logic [6:0] a;
    int         nb;
    int         np;
    bus.start_req  = 1'b0;
    bus.slave_addr = 7'h00;
    bus.tx_data    = 8'h00;
    bus.tx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_scl", 32'(bus.scl), 32'd1);
    checkOutput("reset_sda", 32'(bus.sda_out), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_tx_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_ack_error", 32'(bus.ack_error), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single byte A5 to 0x78");
    stim_q = '{8'hA5};
    applyStimulus(7'h78, -1, 1'b0, 0);
    checkTransaction(7'h78, 1, -1);

    $display("[TB] address NACK");
    stim_q = '{8'h3C, 8'h5A};
    applyStimulus(7'h78, 0, 1'b0, 0);
    checkTransaction(7'h78, 2, 0);

    $display("[TB] three bytes 01 80 FF");
    stim_q = '{8'h01, 8'h80, 8'hFF};
    applyStimulus(7'h78, -1, 1'b0, 0);
    checkTransaction(7'h78, 3, -1);

    $display("[TB] start_req held while busy");
    stim_q = '{8'hC3};
    applyStimulus(7'h78, -1, 1'b1, 0);
    checkTransaction(7'h78, 1, -1);

    $display("[TB] reset during second data bit");
    stim_q = '{8'h11, 8'h22, 8'h33};
    applyStimulus(7'h78, -1, 1'b0, 4 * QTR * 11 + 2 * QTR);
    stim_q = '{8'h96, 8'h69};
    applyStimulus(7'h78, -1, 1'b0, 0);
    checkTransaction(7'h78, 2, -1);

    $display("[TB] randomised transactions");
    for (int t = 0; t < 8; t++) begin
      a  = 7'($urandom);
      nb = int'($urandom_range(0, 3));
      np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb)) : -1;
      stim_q = {};
      for (int i = 0; i < nb; i++) stim_q.push_back(8'($urandom));
      applyStimulus(a, np, bit'($urandom_range(0, 1)), 0);
      checkTransaction(a, nb, np);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
